instruction_decode: RTL and testbench

Second pipeline stage of the MIPS core, directly downstream of instruction fetch. Registers each valid fetched instruction, splits it into fields, reads both source operands from an internal 32 x 32 register file, sign/zero-extends the immediate, resolves the destination register and write-enable, and presents one registered decode bundle per cycle to execute. Also owns the register-file write port driven by writeback.

---
 rtl/instruction_decode_pkg.sv | 47 ++++
 rtl/register_file.sv | 52 +++++
 rtl/instruction_decode.sv | 112 +++++++++++
 tb/tb_instruction_decode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// rtl/instruction_decode_pkg.sv - opcode/funct constants and decode helpers for the decode stage
package instruction_decode_pkg;

    localparam logic [5:0] OP_RTYPE      = 6'h00;
    localparam logic [5:0] OP_JAL        = 6'h03;
    localparam logic [5:0] OP_ALU_FIRST  = 6'h08;
    localparam logic [5:0] OP_ALU_LAST   = 6'h0F;
    localparam logic [5:0] OP_ANDI       = 6'h0C;
    localparam logic [5:0] OP_ORI        = 6'h0D;
    localparam logic [5:0] OP_XORI       = 6'h0E;
    localparam logic [5:0] OP_LOAD_FIRST = 6'h20;
    localparam logic [5:0] OP_LOAD_LAST  = 6'h25;
    localparam logic [5:0] FN_JR         = 6'h08;
    localparam logic [4:0] REG_RA        = 5'd31;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    // Logical immediates are unsigned; every other format sign-extends.
    function automatic logic imm_is_zext(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

    function automatic logic [4:0] dest_select(input logic [5:0] opcode,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        if (opcode == OP_RTYPE)
            return rd;
        else if (opcode == OP_JAL)
            return REG_RA;
        else
            return rt;
    endfunction

    function automatic logic writes_reg(input logic [5:0] opcode, input logic [5:0] funct);
        logic w;
        w = 1'b0;
        if (opcode == OP_RTYPE)
            w = (funct != FN_JR);
        else if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST)
            w = 1'b1;
        else if (opcode >= OP_LOAD_FIRST && opcode <= OP_LOAD_LAST)
            w = 1'b1;
        else if (opcode == OP_JAL)
            w = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file, two async read ports with write bypass, one sync write port
module register_file #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr_a,
    input  logic [AWIDTH-1:0] raddr_b,
    output logic [DWIDTH-1:0] rdata_a,
    output logic [DWIDTH-1:0] rdata_b
);

    localparam int NREGS = 1 << AWIDTH;

    // Register 0 is hardwired to zero, so no storage is kept for it.
    logic [DWIDTH-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale operand.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            if (we && waddr == raddr_a)
                rdata_a = wdata;
            else
                rdata_a = regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            if (we && waddr == raddr_b)
                rdata_b = wdata;
            else
                rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS decode stage: field split, operand read, immediate extend, registered bundle
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                d_i_ce,
    input  logic [IWIDTH-1:0]   d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic                d_i_stall,
    input  logic                d_i_flush,
    input  logic                d_i_wb_we,
    input  logic [AWIDTH-1:0]   d_i_wb_addr,
    input  logic [DWIDTH-1:0]   d_i_wb_data,
    output logic                d_o_ce,
    output logic [PC_WIDTH-1:0] d_o_pc,
    output logic [5:0]          d_o_opcode,
    output logic [5:0]          d_o_funct,
    output logic [4:0]          d_o_shamt,
    output logic [AWIDTH-1:0]   d_o_rs_addr,
    output logic [AWIDTH-1:0]   d_o_rt_addr,
    output logic [DWIDTH-1:0]   d_o_rs_data,
    output logic [DWIDTH-1:0]   d_o_rt_data,
    output logic [DWIDTH-1:0]   d_o_imm,
    output logic [PC_WIDTH-1:0] d_o_jtarget,
    output logic [AWIDTH-1:0]   d_o_dest,
    output logic                d_o_reg_write
);

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic [AWIDTH-1:0]   rs_addr;
    logic [AWIDTH-1:0]   rt_addr;
    logic [AWIDTH-1:0]   rd_addr;
    logic [DWIDTH-1:0]   rs_data;
    logic [DWIDTH-1:0]   rt_data;
    logic [DWIDTH-1:0]   imm;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] jtarget;
    logic [AWIDTH-1:0]   dest;
    logic                reg_write;

    register_file #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_register_file (
        .clk     (d_clk),
        .rst     (d_rst),
        .we      (d_i_wb_we),
        .waddr   (d_i_wb_addr),
        .wdata   (d_i_wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    always_comb begin
        opcode   = d_i_instr[31:26];
        rs_addr  = d_i_instr[25:21];
        rt_addr  = d_i_instr[20:16];
        rd_addr  = d_i_instr[15:11];
        shamt    = d_i_instr[10:6];
        funct    = d_i_instr[5:0];
        imm      = imm_is_zext(opcode) ? {{(DWIDTH-16){1'b0}}, d_i_instr[15:0]}
                                       : {{(DWIDTH-16){d_i_instr[15]}}, d_i_instr[15:0]};
        // Wraps naturally at the top of the address space.
        pc_plus4 = d_i_pc + PC_WIDTH'(4);
        jtarget  = {pc_plus4[PC_WIDTH-1:PC_WIDTH-4], d_i_instr[25:0], 2'b00};
        dest     = dest_select(opcode, rt_addr, rd_addr);
        reg_write = writes_reg(opcode, funct) && (dest != REG_ZERO);
    end

    always_ff @(posedge d_clk) begin
        if (d_rst || d_i_flush || (!d_i_stall && !d_i_ce)) begin
            d_o_ce        <= 1'b0;
            d_o_pc        <= '0;
            d_o_opcode    <= '0;
            d_o_funct     <= '0;
            d_o_shamt     <= '0;
            d_o_rs_addr   <= '0;
            d_o_rt_addr   <= '0;
            d_o_rs_data   <= '0;
            d_o_rt_data   <= '0;
            d_o_imm       <= '0;
            d_o_jtarget   <= '0;
            d_o_dest      <= '0;
            d_o_reg_write <= 1'b0;
        end else if (!d_i_stall) begin
            d_o_ce        <= 1'b1;
            d_o_pc        <= d_i_pc;
            d_o_opcode    <= opcode;
            d_o_funct     <= funct;
            d_o_shamt     <= shamt;
            d_o_rs_addr   <= rs_addr;
            d_o_rt_addr   <= rt_addr;
            d_o_rs_data   <= rs_data;
            d_o_rt_data   <= rt_data;
            d_o_imm       <= imm;
            d_o_jtarget   <= jtarget;
            d_o_dest      <= dest;
            d_o_reg_write <= reg_write;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed self-checking bench for instruction_decode
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        o_ce;
    logic [31:0] o_pc;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;
    logic [4:0]  o_shamt;
    logic [4:0]  o_rs_addr;
    logic [4:0]  o_rt_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm;
    logic [31:0] o_jtarget;
    logic [4:0]  o_dest;
    logic        o_reg_write;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .d_clk         (clk),
        .d_rst         (rst),
        .d_i_ce        (ce),
        .d_i_instr     (instr),
        .d_i_pc        (pc),
        .d_i_stall     (stall),
        .d_i_flush     (flush),
        .d_i_wb_we     (wb_we),
        .d_i_wb_addr   (wb_addr),
        .d_i_wb_data   (wb_data),
        .d_o_ce        (o_ce),
        .d_o_pc        (o_pc),
        .d_o_opcode    (o_opcode),
        .d_o_funct     (o_funct),
        .d_o_shamt     (o_shamt),
        .d_o_rs_addr   (o_rs_addr),
        .d_o_rt_addr   (o_rt_addr),
        .d_o_rs_data   (o_rs_data),
        .d_o_rt_data   (o_rt_data),
        .d_o_imm       (o_imm),
        .d_o_jtarget   (o_jtarget),
        .d_o_dest      (o_dest),
        .d_o_reg_write (o_reg_write)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_bundle(input string tag);
        check({tag, ".ce"}, {31'b0, o_ce}, 32'h0);
        check({tag, ".pc"}, o_pc, 32'h0);
        check({tag, ".fields"}, {15'b0, o_opcode, o_funct, o_shamt}, 32'h0);
        check({tag, ".rs_data"}, o_rs_data, 32'h0);
        check({tag, ".imm"}, o_imm, 32'h0);
        check({tag, ".jtarget"}, o_jtarget, 32'h0);
        check({tag, ".dest_rw"}, {26'b0, o_dest, o_reg_write}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; instr = 32'h2004FFFF; pc = 32'h100;
        stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        step();
        step();
        check_zero_bundle("reset");

        // Read r5 after reset: ADD r1,r5,r5
        rst = 1'b0; instr = 32'h00A50820; pc = 32'h0;
        step();
        check("r5_after_reset.ce", {31'b0, o_ce}, 32'h1);
        check("r5_after_reset.rs", o_rs_data, 32'h0);
        check("r5_after_reset.rs_addr", {27'b0, o_rs_addr}, 32'd5);

        // Writeback r8 while fetch is idle: bubble out
        ce = 1'b0; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hAA;
        step();
        check_zero_bundle("bubble");

        // ADD r3,r8,r0
        ce = 1'b1; wb_we = 1'b0; instr = 32'h01001820; pc = 32'h4;
        step();
        check("add.rs_data", o_rs_data, 32'hAA);
        check("add.rt_data", o_rt_data, 32'h0);
        check("add.dest", {27'b0, o_dest}, 32'd3);
        check("add.reg_write", {31'b0, o_reg_write}, 32'h1);
        check("add.funct", {26'b0, o_funct}, 32'h20);
        check("add.pc", o_pc, 32'h4);

        // Bypass: wb r9 same cycle as ADD r2,r9,r0
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234; instr = 32'h01201020; pc = 32'h8;
        step();
        check("bypass.rs_data", o_rs_data, 32'h1234);
        wb_we = 1'b0;
        step();
        check("r9_stored.rs_data", o_rs_data, 32'h1234);

        // Write to r0 ignored, even with bypass: ADD r3,r0,r0
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF; instr = 32'h00001820;
        step();
        check("r0_bypass.rs", o_rs_data, 32'h0);
        check("r0_bypass.rt", o_rt_data, 32'h0);
        wb_we = 1'b0;
        step();
        check("r0_after.rs", o_rs_data, 32'h0);

        // ADDI r4,r0,-1
        instr = 32'h2004FFFF; pc = 32'h100;
        step();
        check("addi.imm", o_imm, 32'hFFFFFFFF);
        check("addi.dest", {27'b0, o_dest}, 32'd4);
        check("addi.reg_write", {31'b0, o_reg_write}, 32'h1);

        // ORI r4,r0,0xFFFF
        instr = 32'h3404FFFF;
        step();
        check("ori.imm", o_imm, 32'h0000FFFF);
        check("ori.opcode", {26'b0, o_opcode}, 32'h0D);

        // JAL at 0x00400000
        instr = 32'h0C000010; pc = 32'h00400000;
        step();
        check("jal.dest", {27'b0, o_dest}, 32'd31);
        check("jal.jtarget", o_jtarget, 32'h00000040);
        check("jal.reg_write", {31'b0, o_reg_write}, 32'h1);

        // JAL at the top of the address space: pc+4 wraps to 0
        pc = 32'hFFFFFFFC;
        step();
        check("jal_wrap.jtarget", o_jtarget, 32'h00000040);
        check("jal_wrap.pc", o_pc, 32'hFFFFFFFC);

        // SW r5,4(r2)
        instr = 32'hAC450004; pc = 32'h200;
        step();
        check("sw.reg_write", {31'b0, o_reg_write}, 32'h0);
        check("sw.imm", o_imm, 32'h4);

        // JR r31
        instr = 32'h03E00008;
        step();
        check("jr.reg_write", {31'b0, o_reg_write}, 32'h0);
        check("jr.rs_addr", {27'b0, o_rs_addr}, 32'd31);

        // Shift with shamt: SLL r6,r7,5
        instr = 32'h00073140; pc = 32'h204;
        step();
        check("sll.shamt", {27'b0, o_shamt}, 32'd5);
        check("sll.dest", {27'b0, o_dest}, 32'd6);

        // Capture ADDI at 0x300 then stall 3 cycles with changing inputs
        instr = 32'h20040007; pc = 32'h300;
        step();
        stall = 1'b1; wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            instr = 32'h3404FFFF + i; pc = 32'h400 + 4 * i; ce = i[0];
            step();
            check("stall.pc", o_pc, 32'h300);
            check("stall.imm", o_imm, 32'h7);
            check("stall.ce", {31'b0, o_ce}, 32'h1);
        end
        wb_we = 1'b0;

        // Flush together with stall
        flush = 1'b1; ce = 1'b1;
        step();
        check_zero_bundle("flush");

        // Register written during stall is visible: ADD r1,r10,r0
        flush = 1'b0; stall = 1'b0; instr = 32'h01400820; pc = 32'h500;
        step();
        check("r10_after_stall.rs", o_rs_data, 32'h55);

        // Back-to-back stream of 7 ADDIs
        for (int i = 0; i < 7; i++) begin
            instr = 32'h20040000 | i; pc = 4 * i;
            step();
            check("stream.ce", {31'b0, o_ce}, 32'h1);
            check("stream.pc", o_pc, 4 * i);
            check("stream.imm", o_imm, i);
        end

        // Mid-stream reset with a competing writeback, then r8 reads 0
        rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hBEEF;
        step();
        check_zero_bundle("midreset");
        rst = 1'b0; wb_we = 1'b0; instr = 32'h01001820; pc = 32'h600;
        step();
        check("r8_after_reset.rs", o_rs_data, 32'h0);
        check("r8_after_reset.ce", {31'b0, o_ce}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
